// File: rtl/motor_sched.sv
// -----------------------------------------------------------------------------
// motor_sched
//
// Arbitrates two direction requesters (manual and automatic) for a single
// up/down motor. Every move starts with a dead-time interval with the command
// held at idle. The move runs until the target limit switch is reached, a stop
// arrives, a timeout expires, or a manual request takes over.
//
// Parameters
//   DEAD_CYCLES    : idle-command cycles before any motion starts (1..255)
//   TIMEOUT_CYCLES : maximum consecutive RUN cycles before a fault (2..2^32-1)
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   req_man    : manual requester level   (01 up, 10 down, 00/11 none)
//   req_auto   : automatic requester level (same encoding)
//   stop       : synchronous abort, active-high
//   clr_fault  : synchronous fault clear, active-high
//   TopeA_S    : upper limit switch status, active-high
//   TopeB_S    : lower limit switch status, active-high
//   cmd        : registered motor command (00 idle, 01 up, 10 down)
//   grant      : registered owner (01 manual, 10 auto, 00 none)
//   busy       : high while in DEAD or RUN
//   done       : one-cycle pulse when a move completes at its limit
//   fault      : high while in FAULT
// -----------------------------------------------------------------------------
module motor_sched #(
  parameter int unsigned DEAD_CYCLES    = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_man,
  input  logic [1:0] req_auto,
  input  logic       stop,
  input  logic       clr_fault,
  input  logic       TopeA_S,
  input  logic       TopeB_S,
  output logic [1:0] cmd,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_MAN  = 2'b01;
  localparam logic [1:0] OWN_AUTO = 2'b10;

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [1:0]  dir_reg;
  logic [1:0]  cmd_reg;
  logic [1:0]  grant_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        fault_reg;
  logic [7:0]  dead_cnt_reg;
  logic [31:0] run_cnt_reg;

  // True when moving in direction d would drive into an already active limit.
  function automatic logic target_hit(input logic [1:0] d,
                                      input logic       lim_up,
                                      input logic       lim_down);
    return ((d == DIR_UP) && lim_up) || ((d == DIR_DOWN) && lim_down);
  endfunction

  // ---------------------------------------------------------------------------
  // Requester decode: index 0 is manual, index 1 is automatic.
  // req_ok means the level is a real direction and its target limit is free.
  // ---------------------------------------------------------------------------
  logic [1:0] req_bus [2];
  logic [1:0] req_valid;
  logic [1:0] req_ok;

  assign req_bus[0] = req_man;
  assign req_bus[1] = req_auto;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_valid[gi] = (req_bus[gi] == DIR_UP) || (req_bus[gi] == DIR_DOWN);
      assign req_ok[gi]    = req_valid[gi] &&
                             !target_hit(req_bus[gi], TopeA_S, TopeB_S);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-cycle conditions used by the state machine
  // ---------------------------------------------------------------------------
  logic both_limits;
  logic dir_hit;
  logic run_timeout;
  logic preempt_flip;
  logic preempt_same;

  assign both_limits = TopeA_S && TopeB_S;
  assign dir_hit     = target_hit(dir_reg, TopeA_S, TopeB_S);

  // run_cnt_reg holds the number of RUN cycles already spent, starting at 1
  // on the entry edge, so the move is allowed exactly TIMEOUT_CYCLES cycles.
  assign run_timeout = (run_cnt_reg >= TIMEOUT_CYCLES);

  // Only an automatic owner can be displaced, and only by the manual side.
  // Reversing direction needs the new target limit to be free; a reversal
  // straight into an active limit would be pointless and is ignored.
  assign preempt_flip = (grant_reg == OWN_AUTO) && req_ok[0] &&
                        (req_man != dir_reg);
  assign preempt_same = (grant_reg == OWN_AUTO) && req_valid[0] &&
                        (req_man == dir_reg);

  // ---------------------------------------------------------------------------
  // Scheduler state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      dir_reg      <= DIR_NONE;
      cmd_reg      <= DIR_NONE;
      grant_reg    <= OWN_NONE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      dead_cnt_reg <= 8'd0;
      run_cnt_reg  <= 32'd0;
    end else begin
      // done is a single-cycle pulse; only the completion branch raises it.
      done_reg <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (both_limits) begin
            state_reg <= FAULT;
            fault_reg <= 1'b1;
          end else if (stop) begin
            // Abort held in IDLE blocks any acceptance this cycle.
            state_reg <= IDLE;
          end else if (req_ok[0]) begin
            state_reg    <= DEAD;
            dir_reg      <= req_man;
            grant_reg    <= OWN_MAN;
            busy_reg     <= 1'b1;
            dead_cnt_reg <= DEAD_LOAD;
          end else if (req_ok[1]) begin
            // Reached when manual is absent or rejected at its limit.
            state_reg    <= DEAD;
            dir_reg      <= req_auto;
            grant_reg    <= OWN_AUTO;
            busy_reg     <= 1'b1;
            dead_cnt_reg <= DEAD_LOAD;
          end
        end

        DEAD, RUN: begin
          if (both_limits) begin
            state_reg    <= FAULT;
            cmd_reg      <= DIR_NONE;
            grant_reg    <= OWN_NONE;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b1;
            dead_cnt_reg <= 8'd0;
            run_cnt_reg  <= 32'd0;
          end else if (stop) begin
            state_reg    <= IDLE;
            cmd_reg      <= DIR_NONE;
            grant_reg    <= OWN_NONE;
            busy_reg     <= 1'b0;
            dead_cnt_reg <= 8'd0;
            run_cnt_reg  <= 32'd0;
          end else if ((state_reg == RUN) && dir_hit) begin
            state_reg    <= IDLE;
            cmd_reg      <= DIR_NONE;
            grant_reg    <= OWN_NONE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            dead_cnt_reg <= 8'd0;
            run_cnt_reg  <= 32'd0;
          end else if ((state_reg == RUN) && run_timeout) begin
            state_reg    <= FAULT;
            cmd_reg      <= DIR_NONE;
            grant_reg    <= OWN_NONE;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b1;
            dead_cnt_reg <= 8'd0;
            run_cnt_reg  <= 32'd0;
          end else if (preempt_flip) begin
            // Reversal always goes back through a full dead-time interval.
            state_reg    <= DEAD;
            dir_reg      <= req_man;
            cmd_reg      <= DIR_NONE;
            grant_reg    <= OWN_MAN;
            dead_cnt_reg <= DEAD_LOAD;
            run_cnt_reg  <= 32'd0;
          end else begin
            // Same-direction takeover only changes the owner; the move and
            // its counters carry on exactly as before.
            if (preempt_same) begin
              grant_reg <= OWN_MAN;
            end

            if (state_reg == DEAD) begin
              if (dead_cnt_reg <= 8'd1) begin
                state_reg    <= RUN;
                cmd_reg      <= dir_reg;
                dead_cnt_reg <= 8'd0;
                run_cnt_reg  <= 32'd1;
              end else begin
                dead_cnt_reg <= dead_cnt_reg - 8'd1;
              end
            end else begin
              run_cnt_reg <= run_cnt_reg + 32'd1;
            end
          end
        end

        FAULT: begin
          // Clearing is refused while the limit pair is still inconsistent.
          if (clr_fault && !both_limits) begin
            state_reg <= IDLE;
            fault_reg <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          cmd_reg      <= DIR_NONE;
          grant_reg    <= OWN_NONE;
          busy_reg     <= 1'b0;
          fault_reg    <= 1'b0;
          dead_cnt_reg <= 8'd0;
          run_cnt_reg  <= 32'd0;
        end
      endcase
    end
  end

  assign cmd   = cmd_reg;
  assign grant = grant_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign fault = fault_reg;

endmodule

// File: doc/motor_sched.md
MOTOR_SCHED -- requirements
Module: motor_sched

Interface
REQ-001: Parameter DEAD_CYCLES, default 4, cycles with cmd=00 before any motion starts (range 1..255).
REQ-002: Parameter TIMEOUT_CYCLES, default 50000000, maximum consecutive RUN cycles before fault (range 2..2^32-1).
REQ-003: clk  input  1  system clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset; one clock, asynchronous active-low reset as decided for this block.
REQ-005: req_man  input  2  manual requester level: 01 up, 10 down, 00/11 no request.
REQ-006: req_auto  input  2  automatic requester level, same encoding as req_man.
REQ-007: stop  input  1  synchronous abort, active-high.
REQ-008: clr_fault  input  1  synchronous fault clear, active-high.
REQ-009: TopeA_S  input  1  upper limit status from motor block, active-high.
REQ-010: TopeB_S  input  1  lower limit status from motor block, active-high.
REQ-011: cmd  output  2  registered command to motor block: 00 idle, 01 up, 10 down; 11 never driven.
REQ-012: grant  output  2  registered owner: 01 manual, 10 auto, 00 none.
REQ-013: busy  output  1  high in DEAD and RUN.
REQ-014: done  output  1  one-cycle pulse on normal completion at limit.
REQ-015: fault  output  1  high while in FAULT.

Function
REQ-016: FSM states SHALL be IDLE, DEAD, RUN, FAULT; cmd SHALL be 00 in every state except RUN, where it SHALL equal latched direction dir.
REQ-017: Valid request SHALL be 01 or 10; 00 and 11 SHALL be ignored.
REQ-018: In IDLE, manual SHALL win over auto when both valid; the winner's direction and owner SHALL be latched into dir and grant.
REQ-019: In IDLE, a request whose target limit is already active (01 with TopeA_S, 10 with TopeB_S) SHALL be rejected: state stays IDLE, no output changes; lower-priority valid request SHALL then be evaluated the same cycle.
REQ-020: Accepted request at edge N SHALL enter DEAD at N with down-counter loaded to DEAD_CYCLES; cmd SHALL become dir at edge N+DEAD_CYCLES (RUN entry).
REQ-021: In RUN, counter SHALL count consecutive RUN cycles from 1; reaching TIMEOUT_CYCLES SHALL move to FAULT on that edge.
REQ-022: Priority in DEAD and RUN, highest first: both limits high -> FAULT; stop -> IDLE; target limit high (RUN only) -> IDLE with done; timeout -> FAULT; manual preemption.
REQ-023: Limit sampled at edge M in RUN SHALL give cmd=00, busy=0, grant=00 after edge M and done=1 for the cycle following edge M only.
REQ-024: stop SHALL return to IDLE with cmd=00, grant=00, no done pulse; stop in IDLE SHALL block acceptance that cycle.
REQ-025: Preemption: with grant=10, valid manual request of opposite direction SHALL reload DEAD (cmd=00, DEAD_CYCLES) with new dir, grant=01; same direction SHALL transfer grant to 01 without leaving RUN/DEAD or resetting counters.
REQ-026: Auto requests SHALL never preempt; requester dropping its level during DEAD/RUN SHALL NOT stop motion.
REQ-027: Both limits high in IDLE SHALL enter FAULT.
REQ-028: FAULT SHALL hold cmd=00, grant=00, fault=1 until clr_fault=1 with not both limits high, then IDLE.

Reset
REQ-029: reset=0 SHALL immediately force IDLE, cmd=00, grant=00, busy=0, done=0, fault=0, counters 0, regardless of clock, including mid-RUN.
REQ-030: After release, first acceptance SHALL occur no earlier than the first rising edge with reset=1.

Verification (bench DEAD_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-031: req_man=01, limits 0 -> cmd 00 for 4 cycles, then 01; TopeA_S=1 -> cmd 00 next edge, done single pulse, grant 00.
REQ-032: req_auto=10 running, req_man=01 -> grant 01, cmd 00 for 4 cycles, then 01; req_man=10 instead -> grant 01, cmd stays 10.
REQ-033: req_man=10 with no limit for 20 RUN cycles -> fault=1, cmd=00; clr_fault=1 -> IDLE, fault=0.
REQ-034: TopeA_S=1, req_man=01 and req_auto=10 -> auto accepted, grant 10, cmd 10 after 4 cycles.
REQ-035: reset=0 mid-RUN between edges -> cmd=00, busy=0 immediately; stop=1 in RUN -> IDLE, no done.
REQ-036: TopeA_S=TopeB_S=1 in RUN -> FAULT next edge; clr_fault ignored while both remain high.
